// File: rtl/vsmac_drain_if.sv
// Stream bundle for the result-vector drain: packed vector in, one element per transfer out.
interface vsmac_drain_if #(
    parameter int SIZE  = 6,
    parameter int WIDTH = 8
);
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH*SIZE-1:0]  in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [IW-1:0]          out_index;
    logic                   out_last;
    logic                   busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, busy
    );
endinterface

// File: rtl/vsmac_drain.sv
// Serialises one packed MAC result vector into an element stream, element 0 first,
// with optional ReLU; a new vector may load on the same edge the last element leaves.
module vsmac_drain #(
    parameter int SIZE  = 6,
    parameter int WIDTH = 8,
    parameter int RELU  = 0
) (
    input  logic          clk,
    input  logic          reset,
    vsmac_drain_if.slave  bus
);
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]            r_state;
    logic [WIDTH*SIZE-1:0] r_buf;
    logic [IW-1:0]         r_index;

    logic                  w_valid;
    logic                  w_last;
    logic                  w_xfer;
    logic                  w_in_ready;
    logic                  w_cap;
    logic [WIDTH-1:0]      w_elem;
    logic [WIDTH-1:0]      w_elem_act;

    assign w_valid    = (r_state == S_SEND);
    assign w_last     = w_valid && (r_index == IW'(SIZE - 1));
    assign w_xfer     = w_valid && bus.out_ready;
    assign w_in_ready = reset && (!w_valid || (w_xfer && w_last));
    assign w_cap      = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
            r_index <= '0;
        end else if (w_cap) begin
            r_state <= S_SEND;
            r_buf   <= bus.in_data;
            r_index <= '0;
        end else if (w_xfer) begin
            if (w_last) begin
                r_state <= S_IDLE;
                r_index <= '0;
            end else begin
                r_index <= r_index + 1'b1;
            end
        end
    end

    // Element mux built from registered state only, so in_valid never reaches out_*.
    always_comb begin
        w_elem = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (r_index == IW'(i)) begin
                w_elem = r_buf[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_elem_act = w_elem;
        if ((RELU != 0) && w_elem[WIDTH-1]) begin
            w_elem_act = '0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_valid ? w_elem_act : '0;
    assign bus.out_index = r_index;
    assign bus.out_last  = w_last;
    assign bus.busy      = w_valid;
endmodule
